// File: rtl/clkdomain_buf_arb_pkg.sv
// rtl/clkdomain_buf_arb_pkg.sv - shared types and constants for the buffer arbiter
package clkdomain_buf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_LOW = 2'd2,
        WAIT_RDY = 2'd3
    } arb_state_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/clkdomain_buf_arb_rr_pick.sv
// rtl/clkdomain_buf_arb_rr_pick.sv - combinational round-robin pick starting at rr_ptr
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    always_comb begin
        int            j;
        logic [IW-1:0] jj;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        jj    = '0;
        // Walk upward from rr_ptr with wrap; the first set request wins.
        for (int k = 0; k < NREQ; k++) begin
            j  = (int'(rr_ptr) + k) % NREQ;
            jj = IW'(j);
            if (!any && req[jj]) begin
                any       = 1'b1;
                grant[jj] = 1'b1;
                idx       = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/clkdomain_buf_arb.sv
// rtl/clkdomain_buf_arb.sv - round-robin arbiter sharing one CDC buffer input
module clkdomain_buf_arb
    import clkdomain_buf_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH+IDW-1:0]  buf_in,
    output logic                  buf_in_valid,
    input  logic                  buf_in_ready,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   wait_cnt;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  win_idx;
    logic            win_any;
    logic [WIDTH-1:0] win_data;
    logic [IDW-1:0]  next_ptr;
    logic            start;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        next_ptr = win_idx + 1'b1;
        if (int'(win_idx) == NREQ - 1) begin
            next_ptr = '0;
        end
    end

    // Grant only when the buffer is ready, so a valid pulse never hits a busy buffer.
    assign start     = (state == IDLE) && buf_in_ready && win_any;
    assign req_ready = start ? grant : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            buf_in       <= '0;
            buf_in_valid <= 1'b0;
            timeout_err  <= 1'b0;
            xfer_count   <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        buf_in       <= {win_idx, win_data};
                        rr_ptr       <= next_ptr;
                        buf_in_valid <= 1'b1;
                        // Counted on entry so the count is already visible alongside the valid pulse.
                        xfer_count   <= xfer_count + 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    buf_in_valid <= 1'b0;
                    state        <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!buf_in_ready) begin
                        state <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (buf_in_ready) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        if (wait_cnt != CW'(TIMEOUT)) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt == CW'(TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clkdomain_buf_arb.sv
// tb/tb_clkdomain_buf_arb.sv - directed self-checking bench for clkdomain_buf_arb
module tb_clkdomain_buf_arb;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [33:0]  buf_in;
    logic         buf_in_valid;
    logic         buf_in_ready;
    logic         busy;
    logic         timeout_err;
    logic [15:0]  xfer_count;

    logic         drv_ready;
    logic         model_en;
    logic         mdl_ready;
    int           mdl_cnt;
    logic         prev_valid;
    logic         prev_ready;
    int           hs_viol;
    int           gq[$];
    int           gbase;
    int           checks;
    int           failures;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'habcd_6789;
    localparam logic [31:0] D3 = 32'h4444_0003;

    clkdomain_buf_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .buf_in       (buf_in),
        .buf_in_valid (buf_in_valid),
        .buf_in_ready (buf_in_ready),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .xfer_count   (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign buf_in_ready = model_en ? mdl_ready : drv_ready;

    // Buffer model: drops ready after capturing a word, returns it 20 cycles later.
    always @(posedge clk) begin
        if (!model_en) begin
            mdl_ready <= 1'b1;
            mdl_cnt   <= 0;
        end else if (buf_in_valid) begin
            mdl_ready <= 1'b0;
            mdl_cnt   <= 20;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) mdl_ready <= 1'b1;
        end
    end

    initial begin
        hs_viol    = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
    end

    always @(negedge clk) begin
        if (rst_n && buf_in_valid && (prev_valid || !prev_ready)) hs_viol <= hs_viol + 1;
        for (int i = 0; i < 4; i++) begin
            if (req_ready[i]) gq.push_back(i);
        end
        prev_valid <= buf_in_valid;
        prev_ready <= buf_in_ready;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        drv_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        tick();
        drv_ready = 1'b1;
        #1;
    endtask

    // From ISSUE: let the buffer capture, then complete its round trip.
    task automatic complete_hs(input string tag);
        drv_ready = 1'b0;
        tick();
        check(tag, {63'd0, buf_in_valid}, 64'd0);
        tick();
        drv_ready = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_en  = 1'b0;
        drv_ready = 1'b0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = {D3, D2, D1, D0};

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready", {60'd0, req_ready}, 64'd0);
            check("rst_valid", {63'd0, buf_in_valid}, 64'd0);
            check("rst_xfer", {48'd0, xfer_count}, 64'd0);
        end
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;
        tick();
        drv_ready = 1'b1;
        #1;
        check("first_grant", {60'd0, req_ready}, 64'd1);
        tick();
        req_valid = 4'b0000;
        check("first_buf_in", {30'd0, buf_in}, {30'd0, 2'd0, D0});
        complete_hs("first_pulse");

        do_reset();
        req_valid = 4'b0100;
        #1;
        check("single_ready", {60'd0, req_ready}, 64'h4);
        tick();
        req_valid = 4'b0000;
        #1;
        check("single_ready_off", {60'd0, req_ready}, 64'd0);
        check("single_buf_in", {30'd0, buf_in}, 64'h2_abcd6789);
        check("single_valid", {63'd0, buf_in_valid}, 64'd1);
        check("single_xfer", {48'd0, xfer_count}, 64'd1);
        complete_hs("single_pulse");

        req_valid = 4'b0010;
        #1;
        check("rot_pick1a", {60'd0, req_ready}, 64'h2);
        tick();
        req_valid = 4'b0000;
        check("rot_buf1a", {30'd0, buf_in}, {30'd0, 2'd1, D1});
        complete_hs("rot_pulse1a");
        req_valid = 4'b1010;
        #1;
        check("rot_pick3", {60'd0, req_ready}, 64'h8);
        tick();
        req_valid = 4'b0010;
        check("rot_buf3", {30'd0, buf_in}, {30'd0, 2'd3, D3});
        complete_hs("rot_pulse3");
        #1;
        check("rot_pick1b", {60'd0, req_ready}, 64'h2);
        tick();
        req_valid = 4'b0000;
        check("rot_buf1b", {30'd0, buf_in}, {30'd0, 2'd1, D1});
        complete_hs("rot_pulse1b");
        req_valid = 4'b1111;
        #1;
        check("rr_ptr_is_2", {60'd0, req_ready}, 64'h4);
        req_valid = 4'b0000;

        do_reset();
        gbase     = gq.size();
        model_en  = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if (gq.size() - gbase >= 5) break;
            tick();
        end
        check("model_grants", {63'd0, (gq.size() - gbase) >= 5}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("model_order%0d", i), 64'(gq[gbase + i]), 64'(i % 4));
        end
        req_valid = 4'b0000;
        model_en  = 1'b0;
        do_reset();

        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0000;
        drv_ready = 1'b0;
        tick();
        tick();
        repeat (1023) tick();
        check("timeout_before", {63'd0, timeout_err}, 64'd0);
        check("timeout_busy", {63'd0, busy}, 64'd1);
        tick();
        check("timeout_at_1024", {63'd0, timeout_err}, 64'd1);
        repeat (76) tick();
        check("timeout_held", {63'd0, timeout_err}, 64'd1);
        drv_ready = 1'b1;
        tick();
        check("timeout_done", {63'd0, busy}, 64'd0);
        check("timeout_sticky", {63'd0, timeout_err}, 64'd1);
        check("timeout_xfer", {48'd0, xfer_count}, 64'd1);

        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0000;
        drv_ready = 1'b0;
        tick();
        tick();
        tick();
        check("arst_busy_pre", {63'd0, busy}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_valid", {63'd0, buf_in_valid}, 64'd0);
        check("arst_err", {63'd0, timeout_err}, 64'd0);
        check("arst_xfer", {48'd0, xfer_count}, 64'd0);
        check("arst_buf_in", {30'd0, buf_in}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        check("handshake_rules", 64'(hs_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
